mem_arbiter: RTL and testbench

Two-port arbiter sharing the single block-burst main-memory port between the instruction cache (read-only) and the data cache (read/write). It sits between both cache controllers and the `dmemory` block. It serialises requests, holds the memory strobes for exactly one transaction, returns the block to the winning requester with a one-cycle done pulse, and aborts hung transactions with a watchdog.

---
 rtl/mem_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port arbiter sharing the single block-burst main-memory port between
// the instruction cache (read-only) and the data cache (read/write).
// A grant latches the address (and write data), raises one memory strobe
// until the matching done input arrives, and returns the block with a
// one-cycle done pulse. A watchdog aborts transactions that never complete.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : ties alternate, the port not granted last wins (D first after reset)
//   undefined : fixed priority, the D-cache wins every tie
module mem_arbiter #(
    parameter int ADDR_W  = 27,
    parameter int BLOCK_W = 128,
    parameter int TIMEOUT = 64
) (
    input  logic               a_clk_i,
    input  logic               a_reset_n_i,

    // Instruction cache
    input  logic               i_read_i,
    input  logic [ADDR_W-1:0]  i_addr_i,
    output logic               i_busywait_o,
    output logic [BLOCK_W-1:0] i_read_data_o,
    output logic               i_done_o,

    // Data cache
    input  logic               d_read_i,
    input  logic               d_wr_i,
    input  logic [ADDR_W-1:0]  d_addr_i,
    input  logic [BLOCK_W-1:0] d_wr_data_i,
    output logic               d_busywait_o,
    output logic [BLOCK_W-1:0] d_read_data_o,
    output logic               d_done_o,

    // Main memory
    output logic               mem_read_o,
    output logic               mem_wr_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [BLOCK_W-1:0] mem_wr_data_o,
    input  logic [BLOCK_W-1:0] mem_read_data_i,
    input  logic               mem_read_done_i,
    input  logic               mem_write_done_i,

    // Status
    output logic               err_o
);

    // Watchdog counter just wide enough to hold TIMEOUT-1.
    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   wd_cnt_q;
    logic [CNT_W-1:0]   wd_cnt_d;
    logic               mem_read_q;
    logic               mem_wr_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [BLOCK_W-1:0] mem_wr_data_q;
    logic [BLOCK_W-1:0] i_read_data_q;
    logic [BLOCK_W-1:0] d_read_data_q;
    logic               i_done_q;
    logic               d_done_q;
    logic               err_q;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when the D-cache received the most recent grant.
    logic               last_d_q;
`endif

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic op_done;
    logic wd_expire;

    assign i_req = i_read_i;
    assign d_req = d_read_i | d_wr_i;

    // Pick a winner among the pending requests (used only in IDLE).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_d = ~last_d_q;
            grant_i =  last_d_q;
`else
            grant_d = 1'b1;
`endif
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end

    // Decode completion of the operation in flight and the watchdog limit.
    always_comb begin
        op_done   = (mem_read_q & mem_read_done_i) | (mem_wr_q & mem_write_done_i);
        wd_expire = (wd_cnt_q == CNT_LAST);
        wd_cnt_d  = wd_cnt_q + CNT_W'(1);
    end

    // Arbiter FSM with all memory-side and cache-side outputs registered.
    always_ff @(posedge a_clk_i or negedge a_reset_n_i) begin
        if (!a_reset_n_i) begin
            // NOTE: the wide data registers are reset too, because every output must read zero out of reset.
            state_q       <= ST_IDLE;
            wd_cnt_q      <= '0;
            mem_read_q    <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            i_read_data_q <= '0;
            d_read_data_q <= '0;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            err_q         <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q      <= 1'b0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        state_q    <= ST_BUSY_D;
                        wd_cnt_q   <= '0;
                        mem_addr_q <= d_addr_i;
                        // A write-back takes precedence over a simultaneous read.
                        if (d_wr_i) begin
                            mem_wr_q      <= 1'b1;
                            mem_wr_data_q <= d_wr_data_i;
                        end else begin
                            mem_read_q    <= 1'b1;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q   <= 1'b1;
`endif
                    end else if (grant_i) begin
                        state_q    <= ST_BUSY_I;
                        wd_cnt_q   <= '0;
                        mem_addr_q <= i_addr_i;
                        mem_read_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q   <= 1'b0;
`endif
                    end
                end

                ST_BUSY_I, ST_BUSY_D: begin
                    if (op_done || wd_expire) begin
                        // Drop the strobe on this edge so the memory never
                        // sees it high again when it returns to idle.
                        mem_read_q <= 1'b0;
                        mem_wr_q   <= 1'b0;
                        state_q    <= ST_RESP;
                        if (state_q == ST_BUSY_I) begin
                            i_done_q <= 1'b1;
                        end else begin
                            d_done_q <= 1'b1;
                        end

                        if (op_done) begin
                            // Only a read returns a block; writes leave it alone.
                            if (mem_read_q) begin
                                if (state_q == ST_BUSY_I) begin
                                    i_read_data_q <= mem_read_data_i;
                                end else begin
                                    d_read_data_q <= mem_read_data_i;
                                end
                            end
                        end else begin
                            // Abort: hand back a zero block and flag it.
                            err_q <= 1'b1;
                            if (state_q == ST_BUSY_I) begin
                                i_read_data_q <= '0;
                            end else begin
                                d_read_data_q <= '0;
                            end
                        end
                    end else begin
                        wd_cnt_q <= wd_cnt_d;
                    end
                end

                ST_RESP: begin
                    // Requests are not looked at here; a request still high
                    // next cycle is treated as a new one.
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_read_o    = mem_read_q;
    assign mem_wr_o      = mem_wr_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wr_data_o = mem_wr_data_q;
    assign i_read_data_o = i_read_data_q;
    assign d_read_data_o = d_read_data_q;
    assign i_done_o      = i_done_q;
    assign d_done_o      = d_done_q;
    assign err_o         = err_q;

    // Stall a cache while its request is up, except in its done cycle.
    assign i_busywait_o  = i_req & ~i_done_q;
    assign d_busywait_o  = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A transaction-level model predicts the
// winner, strobe, latched address/data, returned block, done pulse, busywaits
// and error flag for each request; the bench also plays the memory side.
// Honours ARB_ROUND_ROBIN_EN in its tie-breaking prediction.
module tb_mem_arbiter;

    localparam int AW  = 27;
    localparam int BW  = 128;
    localparam int TMO = 8;

    logic          clk;
    logic          rst_n;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic          i_busywait;
    logic [BW-1:0] i_read_data;
    logic          i_done;
    logic          d_read;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [BW-1:0] d_wr_data;
    logic          d_busywait;
    logic [BW-1:0] d_read_data;
    logic          d_done;
    logic          mem_read;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wr_data;
    logic [BW-1:0] mem_read_data;
    logic          mem_read_done;
    logic          mem_write_done;
    logic          err;

    mem_arbiter #(
        .ADDR_W (AW),
        .BLOCK_W(BW),
        .TIMEOUT(TMO)
    ) dut (
        .a_clk_i         (clk),
        .a_reset_n_i     (rst_n),
        .i_read_i        (i_read),
        .i_addr_i        (i_addr),
        .i_busywait_o    (i_busywait),
        .i_read_data_o   (i_read_data),
        .i_done_o        (i_done),
        .d_read_i        (d_read),
        .d_wr_i          (d_wr),
        .d_addr_i        (d_addr),
        .d_wr_data_i     (d_wr_data),
        .d_busywait_o    (d_busywait),
        .d_read_data_o   (d_read_data),
        .d_done_o        (d_done),
        .mem_read_o      (mem_read),
        .mem_wr_o        (mem_wr),
        .mem_addr_o      (mem_addr),
        .mem_wr_data_o   (mem_wr_data),
        .mem_read_data_i (mem_read_data),
        .mem_read_done_i (mem_read_done),
        .mem_write_done_i(mem_write_done),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state
    logic [BW-1:0] exp_i_rdata;
    logic [BW-1:0] exp_d_rdata;
    logic [BW-1:0] exp_wr_data;
    logic [AW-1:0] exp_addr;
    bit            exp_err;
    bit            last_d;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        exp_wr_data = '0;
        exp_addr    = '0;
        exp_err     = 1'b0;
        last_d      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mrd"},   mem_read,    '0);
        check({tag, "_mwr"},   mem_wr,      '0);
        check({tag, "_maddr"}, mem_addr,    '0);
        check({tag, "_mwd"},   mem_wr_data, '0);
        check({tag, "_irdat"}, i_read_data, '0);
        check({tag, "_drdat"}, d_read_data, '0);
        check({tag, "_idone"}, i_done,      '0);
        check({tag, "_ddone"}, d_done,      '0);
        check({tag, "_ibusy"}, i_busywait,  '0);
        check({tag, "_dbusy"}, d_busywait,  '0);
        check({tag, "_err"},   err,         '0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_wr = 1'b0;
        mem_read_done = 1'b0; mem_write_done = 1'b0;
        #1;
        check_all_zero("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One transaction, entered and left at a negedge in an IDLE cycle.
    // lat: cycles the strobe stays high before memory answers (lat > TMO: never).
    task automatic run_txn(input bit ir, input bit dr, input bit dw,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic [BW-1:0] wd, input int lat, input bit hold,
                           input bit bad_done, input logic [BW-1:0] rdata);
        bit dreq, win_d, is_wr, tmo;
        int n_busy;
        dreq = dr | dw;
        if (ir && dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_d = !last_d;
`else
            win_d = 1'b1;
`endif
        end else begin
            win_d = dreq;
        end
        last_d   = win_d;
        is_wr    = win_d && dw;
        tmo      = (lat > TMO);
        n_busy   = tmo ? TMO : lat;
        exp_addr = win_d ? da : ia;
        if (is_wr) exp_wr_data = wd;

        i_read = ir; i_addr = ia;
        d_read = dr; d_wr = dw; d_addr = da; d_wr_data = wd;

        for (int c = 1; c <= n_busy; c++) begin
            @(negedge clk);
            check("busy_mrd",   mem_read,    !is_wr);
            check("busy_mwr",   mem_wr,      is_wr);
            check("busy_addr",  mem_addr,    exp_addr);
            check("busy_wdata", mem_wr_data, exp_wr_data);
            check("busy_ibusy", i_busywait,  ir);
            check("busy_dbusy", d_busywait,  dreq);
            check("busy_idone", i_done,      1'b0);
            check("busy_ddone", d_done,      1'b0);
            check("busy_err",   err,         exp_err);
            mem_read_done  = 1'b0;
            mem_write_done = 1'b0;
            mem_read_data  = rand_block();
            if (bad_done && c == 1 && lat >= 2) begin
                if (is_wr) mem_read_done  = 1'b1;
                else       mem_write_done = 1'b1;
            end
            if (c == lat) begin
                if (is_wr) begin
                    mem_write_done = 1'b1;
                end else begin
                    mem_read_done = 1'b1;
                    mem_read_data = rdata;
                end
            end
        end

        // Response cycle
        @(negedge clk);
        mem_read_done  = 1'b0;
        mem_write_done = 1'b0;
        mem_read_data  = rand_block();
        if (tmo) begin
            exp_err = 1'b1;
            if (win_d) exp_d_rdata = '0;
            else       exp_i_rdata = '0;
        end else if (!is_wr) begin
            if (win_d) exp_d_rdata = rdata;
            else       exp_i_rdata = rdata;
        end
        check("resp_mrd",   mem_read,    1'b0);
        check("resp_mwr",   mem_wr,      1'b0);
        check("resp_idone", i_done,      !win_d);
        check("resp_ddone", d_done,      win_d);
        check("resp_ibusy", i_busywait,  ir && win_d);
        check("resp_dbusy", d_busywait,  dreq && !win_d);
        check("resp_irdat", i_read_data, exp_i_rdata);
        check("resp_drdat", d_read_data, exp_d_rdata);
        check("resp_err",   err,         exp_err);
        if (!hold) begin
            i_read = 1'b0; d_read = 1'b0; d_wr = 1'b0;
        end

        // Back in IDLE: nothing may start on this edge
        @(negedge clk);
        check("idle_mrd",   mem_read,    1'b0);
        check("idle_mwr",   mem_wr,      1'b0);
        check("idle_idone", i_done,      1'b0);
        check("idle_ddone", d_done,      1'b0);
        check("idle_ibusy", i_busywait,  hold && ir);
        check("idle_dbusy", d_busywait,  hold && dreq);
        check("idle_irdat", i_read_data, exp_i_rdata);
        check("idle_drdat", d_read_data, exp_d_rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1, "bench time limit");
    end

    initial begin
        i_addr = '0; d_addr = '0; d_wr_data = '0; mem_read_data = '0;
        model_reset();
        reset_dut();

        // Reset two cycles into a D-cache write: strobe drops at once, no done.
        d_wr = 1'b1; d_addr = 27'h3; d_wr_data = rand_block();
        @(negedge clk);
        check("rstmid_wr_up", mem_wr, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_wr",   mem_wr, 1'b0);
        check("rstmid_done", d_done, 1'b0);
        check("rstmid_err",  err,    1'b0);
        d_wr = 1'b0;
        @(negedge clk);
        check("rstmid_done2", d_done, 1'b0);
        rst_n = 1'b1;
        model_reset();

        // Single I read, memory answers after 6 cycles.
        run_txn(1, 0, 0, 27'h10, '0, '0, 6, 0, 0, 128'h01234567_89ABCDEF_CAFEF00D_DEADBEEF);
        // D read then D write-back: read block must survive the write.
        run_txn(0, 1, 0, '0, 27'h7, '0, 3, 0, 1, 128'h55555555_66666666_77777777_88888888);
        run_txn(0, 0, 1, '0, 27'h3, 128'h44444444_33333333_22222222_11111111, 4, 0, 1, rand_block());
        // Write and read together: write wins.
        run_txn(0, 1, 1, '0, 27'h9, rand_block(), 1, 0, 0, rand_block());

        // Simultaneous I and D reads straight after reset, three rounds.
        reset_dut();
        run_txn(1, 1, 0, 27'h20, 27'h40, '0, 2, 1, 0, rand_block());
        run_txn(1, 1, 0, 27'h20, 27'h40, '0, 2, 1, 0, rand_block());
        run_txn(1, 1, 0, 27'h20, 27'h40, '0, 2, 0, 0, rand_block());

        // Request held past the done pulse restarts at edge N+2, same address.
        run_txn(1, 0, 0, 27'h55, '0, '0, 3, 1, 0, rand_block());
        run_txn(1, 0, 0, 27'h55, '0, '0, 3, 0, 0, rand_block());

        // Randomized traffic; timeouts only on reads.
        for (int t = 0; t < 150; t++) begin
            bit ir, dr, dw, hold, bad;
            int lat;
            logic [AW-1:0] ia, da;
            logic [BW-1:0] wd, rd;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 2) == 0);
            if (!(ir || dr || dw)) ir = 1'b1;
            lat = $urandom_range(1, TMO);
            if (!dw && $urandom_range(0, 11) == 0) lat = 40;
            hold = ($urandom_range(0, 3) == 0);
            bad  = 1'($urandom_range(0, 1));
            ia = AW'($urandom);
            da = AW'($urandom);
            wd = rand_block();
            rd = rand_block();
            run_txn(ir, dr, dw, ia, da, wd, lat, hold, bad, rd);
            if (hold) run_txn(ir, dr, dw, ia, da, wd, lat, 0, bad, rand_block());
        end

        // Watchdog: D read that memory never answers.
        reset_dut();
        run_txn(0, 1, 0, '0, 27'h12, '0, 1, 0, 0, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000);
        run_txn(0, 1, 0, '0, 27'h13, '0, 1000, 0, 0, rand_block());
        run_txn(1, 0, 0, 27'h14, '0, '0, 2, 0, 0, rand_block());
        check("err_sticky", err, 1'b1);
        reset_dut();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
